alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single 8-bit combinational ALU between N_REQ requesters, for example a fetch/PC-increment unit and an execute unit.
- Round-robin arbitration selects one requester; operands and op code are latched and driven onto the ALU for one cycle.
- The result and zero flag are captured and returned to the granted requester over a valid/ready response channel.
- Sits between the requesters and the ALU instance; the ALU stays external.

Parameters:
- N_REQ, 2, number of requesters (legal range 2..8).
- GW, $clog2(N_REQ), width of the grant index (derived, not overridable).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester request accept.
- req_a  in  N_REQ*8  packed operand A; slice i = [8i+7:8i].
- req_b  in  N_REQ*8  packed operand B.
- req_op  in  N_REQ*3  packed ALU control code.
- rsp_valid  out  N_REQ  per-requester response valid.
- rsp_ready  in  N_REQ  per-requester response accept.
- rsp_result  out  8  result; meaningful only while any rsp_valid bit is high.
- rsp_zero  out  1  zero flag, captured with the result.
- alu_srca  out  8  to ALU SrcA.
- alu_srcb  out  8  to ALU SrcB.
- alu_ctrl  out  3  to ALU ULAControl.
- alu_result  in  8  from ALU ULAResult.
- alu_z  in  1  from ALU Z.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  GW  index of the current or last granted requester.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset values:
  - state = IDLE; rr pointer = 0; grant_id = 0.
  - Latched A, B and op = 0; result and zero registers = 0.
  - All req_ready and rsp_valid bits = 0.
  - alu_srca, alu_srcb and alu_ctrl = 0; busy = 0.
- IDLE:
  - Grant = first i with req_valid[i]=1, searching upward from the rr pointer with wrap (N_REQ-1 wraps to 0).
  - req_ready is one-hot at the grant index. It is combinational and asserted only in IDLE while some req_valid is high; otherwise all bits are 0.
  - On the handshake: latch req_a, req_b and req_op of the winner; set grant_id = winner; go to EXEC.
  - If no request is valid, stay in IDLE.
- EXEC (exactly 1 cycle):
  - alu_srca/srcb/ctrl are driven from the latched registers. They are registered outputs and hold their values in all other states, so the ALU input is glitch-free.
  - At the end of the cycle, capture alu_result and alu_z; go to RESP.
- RESP:
  - rsp_valid[grant_id] = 1, all other bits 0.
  - rsp_result and rsp_zero are held stable until rsp_ready[grant_id] = 1.
  - On that handshake: rr pointer = (grant_id+1) mod N_REQ; go to IDLE.
  - rsp_ready bits of non-granted requesters are ignored.
- Latency and throughput:
  - Accept in cycle T, rsp_valid asserted in cycle T+2 at the earliest.
  - One operation per 3 cycles when rsp_ready is held high.
- No new request is accepted before the previous response handshake completes; only one transaction is in flight at a time.
- Op codes are forwarded unmodified. Undefined codes 3, 4 and 5 return result 0 and zero 1, as produced by the ALU.
- req_valid dropped in IDLE before the handshake: no grant. The arbiter holds no state for un-accepted requests.
- Starvation freedom: a requester holding req_valid waits at most N_REQ-1 transactions.
- Asynchronous reset asserted mid-transaction:
  - Returns immediately to reset values; the in-flight op is discarded and no response is issued.
  - After deassertion, arbitration restarts from pointer 0.

Decomposition:
- Package alu_pkg:
  - Op code constants: ALU_AND=3'd0, ALU_OR=3'd1, ALU_ADD=3'd2, ALU_SUB=3'd6, ALU_SLT=3'd7.
  - Typedef alu_op_t (logic [2:0]).
  - Enum arb_state_t {IDLE, EXEC, RESP}.
- Sub-module rr_arbiter (parameter N):
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, grant index, any-grant.
  - Purely combinational, reusable.

Test Plan:
1. Single requester: req 0 with A=8'h05, B=8'h03, op=2, rsp_ready=1. Expect rsp_valid[0] two cycles after accept, rsp_result=8'h08, rsp_zero=0.
2. SUB to zero and SLT: A=B=8'h2A, op=6, gives result 8'h00, zero=1. Then A=8'h01, B=8'h02, op=7 gives result 8'h01, zero=0.
3. Contention, N_REQ=2: both requesters continuously valid. Grants alternate 0,1,0,1 with no repeats; each response carries the correct requester's operands.
4. Response backpressure: rsp_ready held low for 5 cycles. rsp_valid and the result stay stable, req_ready stays 0 for all requesters, and req 1 is not accepted until the handshake completes.
5. Reset in EXEC: rst_n pulsed low during EXEC. busy=0 immediately, no rsp_valid afterwards, grant_id=0; the next request is served normally.
6. Undefined op: op=3 with A=8'hFF, B=8'hFF. Expect rsp_result=8'h00, rsp_zero=1, and alu_ctrl observed as 3'd3 during EXEC.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes and arbiter state type shared by the ALU arbiter slice
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_AND = 3'd0;
    localparam alu_op_t ALU_OR  = 3'd1;
    localparam alu_op_t ALU_ADD = 3'd2;
    localparam alu_op_t ALU_SUB = 3'd6;
    localparam alu_op_t ALU_SLT = 3'd7;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester at or above ptr with wrap
module rr_arbiter #(
    parameter int N = 2,
    localparam int GW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [GW-1:0] idx,
    output logic          any
);

    // scan offsets from the top down so the smallest offset from ptr wins
    always_comb begin
        int j;
        j = 0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req[j[GW-1:0]]) idx = j[GW-1:0];
        end
        any = |req;
        gnt = any ? N'(1) << idx : '0;
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU among N_REQ requesters, one transaction in flight
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    localparam int GW = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*8-1:0] req_a,
    input  logic [N_REQ*8-1:0] req_b,
    input  logic [N_REQ*3-1:0] req_op,
    output logic [N_REQ-1:0]   rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output logic [7:0]       rsp_result,
    output logic             rsp_zero,
    output logic [7:0]       alu_srca,
    output logic [7:0]       alu_srcb,
    output logic [2:0]       alu_ctrl,
    input  logic [7:0]       alu_result,
    input  logic             alu_z,
    output logic             busy,
    output logic [GW-1:0]    grant_id
);

    arb_state_t state, nstate;
    logic [GW-1:0] ptr, widx;
    logic [N_REQ-1:0] wgnt;
    logic wany, acc, done, zr;
    logic [7:0] sel_a, sel_b, res;
    alu_op_t sel_op;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req(req_valid),
        .ptr(ptr),
        .gnt(wgnt),
        .idx(widx),
        .any(wany)
    );

    assign acc = state == IDLE && wany;
    assign done = state == RESP && rsp_ready[grant_id];
    assign rsp_result = res;
    assign rsp_zero = zr;

    // route the winner's operand slices toward the operand registers
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_op = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (wgnt[i]) begin
                sel_a = req_a[i*8 +: 8];
                sel_b = req_b[i*8 +: 8];
                sel_op = req_op[i*3 +: 3];
            end
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nstate;
    end

    // next state: EXEC always lasts one cycle, RESP waits for the granted requester
    always_comb nstate = state == IDLE ? (wany ? EXEC : IDLE) : state == EXEC ? RESP : (done ? IDLE : RESP);

    // outputs decoded from state
    always_comb begin
        busy = state != IDLE;
        req_ready = state == IDLE ? wgnt : '0;
        rsp_valid = state == RESP ? N_REQ'(1) << grant_id : '0;
    end

    // ALU inputs double as the operand latch so they only change on a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_srca <= '0;
            alu_srcb <= '0;
            alu_ctrl <= '0;
            grant_id <= '0;
            res <= '0;
            zr <= 1'b0;
            ptr <= '0;
        end else begin
            if (acc) begin
                alu_srca <= sel_a;
                alu_srcb <= sel_b;
                alu_ctrl <= sel_op;
                grant_id <= widx;
            end
            if (state == EXEC) begin
                res <= alu_result;
                zr <= alu_z;
            end
            if (done) ptr <= grant_id == GW'(N_REQ - 1) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with N_REQ=2 and a behavioural ALU
module tb_alu_arbiter;

    typedef struct { logic [7:0] a; logic [7:0] b; logic [2:0] op; } req_t;
    typedef struct { int id; logic [7:0] a; logic [7:0] b; logic [2:0] op; logic [7:0] res; logic z; } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] req_valid = '0;
    logic [1:0] req_ready;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic [5:0] req_op = '0;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready = '0;
    logic [7:0] rsp_result;
    logic rsp_zero;
    logic [7:0] alu_srca, alu_srcb, alu_result;
    logic [2:0] alu_ctrl;
    logic alu_z;
    logic busy;
    logic grant_id;

    int total = 0;
    int bad = 0;

    req_t p0[$];
    req_t p1[$];
    exp_t sb[$];
    int cyc = 0;
    int acc_cyc = 0;
    int m_ptr = 0;
    int cur_id = 0;
    bit inflight = 1'b0;
    logic [1:0] acc_mask = '0;

    alu_arbiter #(.N_REQ(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .req_op(req_op),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_result(rsp_result),
        .rsp_zero(rsp_zero),
        .alu_srca(alu_srca),
        .alu_srcb(alu_srcb),
        .alu_ctrl(alu_ctrl),
        .alu_result(alu_result),
        .alu_z(alu_z),
        .busy(busy),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd6: return a - b;
            3'd7: return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_srca, alu_srcb, alu_ctrl);
    assign alu_z = alu_result == 8'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: arbitration, latency and expected responses
    always @(negedge clk or negedge rst_n) begin
        logic [1:0] exp_rdy, exp_rv;
        int pick;
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            inflight = 1'b0;
            m_ptr = 0;
            acc_mask = '0;
        end else begin
            cyc++;
            pick = -1;
            if (!inflight)
                for (int k = 0; k < 2; k++)
                    if (pick < 0 && req_valid[(m_ptr + k) % 2]) pick = (m_ptr + k) % 2;
            exp_rdy = pick >= 0 ? 2'b01 << pick : 2'b00;
            exp_rv = (inflight && cyc - acc_cyc >= 2) ? 2'b01 << cur_id : 2'b00;
            chk("req_ready", req_ready, exp_rdy);
            chk("busy", busy, inflight);
            chk("rsp_valid", rsp_valid, exp_rv);
            if (inflight && cyc - acc_cyc == 1) begin
                chk("exec_srca", alu_srca, sb[0].a);
                chk("exec_srcb", alu_srcb, sb[0].b);
                chk("exec_ctrl", alu_ctrl, sb[0].op);
            end
            if (exp_rv != 2'b00) begin
                chk("rsp_result", rsp_result, sb[0].res);
                chk("rsp_zero", rsp_zero, sb[0].z);
                chk("grant_id", grant_id, cur_id);
                if (rsp_ready[cur_id]) begin
                    e = sb.pop_front();
                    m_ptr = (cur_id + 1) % 2;
                    inflight = 1'b0;
                end
            end
            acc_mask = req_valid & req_ready;
            if (pick >= 0) begin
                e.id = pick;
                e.a = req_a[pick*8 +: 8];
                e.b = req_b[pick*8 +: 8];
                e.op = req_op[pick*3 +: 3];
                e.res = alu_f(e.a, e.b, e.op);
                e.z = e.res == 8'd0;
                sb.push_back(e);
                inflight = 1'b1;
                acc_cyc = cyc;
                cur_id = pick;
            end
        end
    end

    task automatic present();
        req_valid[0] = p0.size() > 0;
        req_valid[1] = p1.size() > 0;
        if (p0.size() > 0) begin
            req_a[7:0] = p0[0].a;
            req_b[7:0] = p0[0].b;
            req_op[2:0] = p0[0].op;
        end
        if (p1.size() > 0) begin
            req_a[15:8] = p1[0].a;
            req_b[15:8] = p1[0].b;
            req_op[5:3] = p1[0].op;
        end
    endtask

    task automatic step();
        req_t r;
        @(posedge clk);
        #1;
        if (acc_mask[0] && p0.size() > 0) r = p0.pop_front();
        if (acc_mask[1] && p1.size() > 0) r = p1.pop_front();
        present();
    endtask

    task automatic push(input int id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        req_t r;
        r.a = a;
        r.b = b;
        r.op = op;
        if (id == 0) p0.push_back(r);
        else p1.push_back(r);
        present();
    endtask

    task automatic drain(input string tag);
        int n;
        for (n = 0; n < 200 && (p0.size() > 0 || p1.size() > 0 || inflight); n++) step();
        chk(tag, n < 200, 1);
    endtask

    initial begin
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_srca", alu_srca, 0);
        chk("rst_srcb", alu_srcb, 0);
        chk("rst_ctrl", alu_ctrl, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_zero", rsp_zero, 0);
        #9 rst_n = 1'b1;
        rsp_ready = 2'b11;
        step();
        push(0, 8'h05, 8'h03, 3'd2);
        drain("t1_drain");
        push(0, 8'h2A, 8'h2A, 3'd6);
        push(0, 8'h01, 8'h02, 3'd7);
        drain("t2_drain");
        for (int i = 0; i < 3; i++) begin
            push(0, 8'(8'h10 + i), 8'h01, 3'd2);
            push(1, 8'(8'hF0 + i), 8'h0F, 3'd0);
        end
        drain("t3_drain");
        rsp_ready = 2'b00;
        push(0, 8'h33, 8'h0C, 3'd1);
        push(1, 8'h40, 8'h01, 3'd6);
        for (int n = 0; n < 20 && !(inflight && cyc - acc_cyc >= 2); n++) step();
        chk("bp_valid", |rsp_valid, 1);
        rsp_ready = cur_id == 0 ? 2'b10 : 2'b01;
        repeat (5) step();
        chk("bp_hold", |rsp_valid, 1);
        rsp_ready = 2'b11;
        drain("t4_drain");
        push(1, 8'h10, 8'h20, 3'd2);
        for (int n = 0; n < 20 && p1.size() > 0; n++) step();
        chk("rst_acc", p1.size(), 0);
        chk("exec_gid", grant_id, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_gid", grant_id, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_ctrl", alu_ctrl, 0);
        #1 rst_n = 1'b1;
        repeat (4) step();
        push(0, 8'h07, 8'h09, 3'd0);
        push(1, 8'h07, 8'h09, 3'd1);
        drain("t5_drain");
        push(0, 8'hFF, 8'hFF, 3'd3);
        drain("t6_drain");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
